// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the signed-overflow rule applied when a result completes.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } sub_state_e;

    // Overflow when operand signs differ and the result sign differs from the minuend.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
        return (a_msb ^ b_msb) & (a_msb ^ d_msb);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit difference/borrow cell used once by the serial datapath.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);

    assign diff = x ^ y ^ bi;
    assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one bit per clock, LSB first, through a single
// full_subtractor cell. Results are published only when an operation completes.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    sub_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             bit_diff;
    logic             bit_bo;
    logic [WIDTH-1:0] res_shift;

    full_subtractor u_fs (
        .x   (a_q[0]),
        .y   (b_q[0]),
        .bi  (br_q),
        .diff(bit_diff),
        .bo  (bit_bo)
    );

    // Result fills from the top so the LSB lands at bit 0 after WIDTH shifts.
    assign res_shift = {bit_diff, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        d_d     = d_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                res_d = res_shift;
                br_d  = bit_bo;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    d_d     = res_shift;
                    bout_d  = bit_bo;
                    ovf_d   = sub_ovf(a_msb_q, b_msb_q, bit_diff);
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed table, random ops against an
// arithmetic model, and multi-cycle corner sequences at WIDTH 8, 2 and 64.
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] d;
        logic       bout;
        logic       ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    logic       start, bin, busy, done, bout, ovf;
    logic [7:0] a, b, d;

    logic       start2, bin2, busy2, done2, bout2, ovf2;
    logic [1:0] a2, b2, d2;

    logic        start64, bin64, busy64, done64, bout64, ovf64;
    logic [63:0] a64, b64, d64;

    int checks = 0;
    int errors = 0;
    logic [7:0] last_d;
    vec_t vecs[6];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .d(d), .bout(bout), .ovf(ovf)
    );

    serial_subtractor #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
        .busy(busy2), .done(done2), .d(d2), .bout(bout2), .ovf(ovf2)
    );

    serial_subtractor #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst(rst), .start(start64), .a(a64), .b(b64), .bin(bin64),
        .busy(busy64), .done(done64), .d(d64), .bout(bout64), .ovf(ovf64)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic vec_t model(input logic [7:0] ia, input logic [7:0] ib, input logic ibin);
        vec_t v;
        int ud, sd;
        ud = int'(ia) - int'(ib) - int'(ibin);
        sd = int'($signed(ia)) - int'($signed(ib)) - int'(ibin);
        v.a = ia;
        v.b = ib;
        v.bin = ibin;
        v.d = ud[7:0];
        v.bout = (ud < 0);
        v.ovf = (sd < -128) || (sd > 127);
        return v;
    endfunction

    // One full operation on the 8-bit DUT, checking latency, busy span, hold and result.
    task automatic run_op(input vec_t v, input string tag);
        int n;
        int busy_cnt;
        @(negedge clk);
        a = v.a;
        b = v.b;
        bin = v.bin;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        bin = ~v.bin;
        n = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) busy_cnt++;
            if (n == 4) check({tag, " d hold"}, d, last_d);
        end
        check({tag, " latency"}, n, 8);
        check({tag, " busy cycles"}, busy_cnt, 8);
        check({tag, " d"}, d, v.d);
        check({tag, " bout"}, bout, v.bout);
        check({tag, " ovf"}, ovf, v.ovf);
        last_d = v.d;
        @(posedge clk);
        #1;
        check({tag, " done one cycle"}, done, 1'b0);
    endtask

    initial begin
        int n;
        int seen_done;
        vec_t v;

        vecs[0] = '{a: 8'h05, b: 8'h03, bin: 1'b0, d: 8'h02, bout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'h03, b: 8'h05, bin: 1'b0, d: 8'hFE, bout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h80, b: 8'h01, bin: 1'b0, d: 8'h7F, bout: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: 8'h00, b: 8'h00, bin: 1'b1, d: 8'hFF, bout: 1'b1, ovf: 1'b0};
        vecs[4] = '{a: 8'h7F, b: 8'hFF, bin: 1'b0, d: 8'h80, bout: 1'b1, ovf: 1'b1};
        vecs[5] = '{a: 8'hFF, b: 8'hFF, bin: 1'b1, d: 8'hFF, bout: 1'b1, ovf: 1'b0};

        rst = 1'b1;
        start = 1'b0; a = '0; b = '0; bin = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
        start64 = 1'b0; a64 = '0; b64 = '0; bin64 = 1'b0;
        last_d = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset d", d, 8'h00);
        check("reset bout", bout, 1'b0);
        check("reset ovf", ovf, 1'b0);

        // First start is accepted on the first edge after release.
        @(negedge clk);
        rst = 1'b0;
        a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("first start accepted", busy, 1'b1);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("first op latency", n, 8);
        check("first op d", d, 8'h02);
        last_d = 8'h02;
        @(posedge clk);

        for (int i = 0; i < 6; i++) run_op(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            v = model(8'($urandom), 8'($urandom), 1'($urandom));
            run_op(v, $sformatf("rand%0d", i));
        end

        // start held high: one op per acceptance, DONE ignores it, IDLE re-accepts.
        @(negedge clk);
        a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        a = 8'h40; b = 8'h01;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("held latency", n, 8);
        check("held first d", d, 8'h02);
        @(posedge clk);
        #1;
        check("held done->idle busy", busy, 1'b0);
        check("held done->idle done", done, 1'b0);
        @(posedge clk);
        #1;
        check("held second accepted", busy, 1'b1);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("held d during second run", d, 8'h02);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("held second d", d, 8'h3F);
        last_d = 8'h3F;
        @(posedge clk);

        // Reset after the 3rd RUN edge aborts the op with no done pulse.
        @(negedge clk);
        a = 8'h55; b = 8'h11; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort d", d, 8'h00);
        check("abort bout", bout, 1'b0);
        check("abort ovf", ovf, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        check("abort no done", seen_done, 0);
        last_d = 8'h00;
        run_op(model(8'h10, 8'h01, 1'b0), "post abort");

        // Width extremes: 0 - 1 gives all ones with a borrow.
        @(negedge clk);
        a2 = 2'd0; b2 = 2'd1; bin2 = 1'b0; start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        n = 0;
        while (!done2 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("w2 latency", n, 2);
        check("w2 d", d2, 2'b11);
        check("w2 bout", bout2, 1'b1);
        check("w2 ovf", ovf2, 1'b0);

        @(negedge clk);
        a64 = 64'd0; b64 = 64'd1; bin64 = 1'b0; start64 = 1'b1;
        @(posedge clk);
        #1;
        start64 = 1'b0;
        n = 0;
        while (!done64 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("w64 latency", n, 64);
        check("w64 d", d64, {64{1'b1}});
        check("w64 bout", bout64, 1'b1);
        check("w64 ovf", ovf64, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
